// File: rtl/accel_pkg.sv
// accel_pkg
//   Shared defaults for the accelerator core: array geometry, data widths,
//   SRAM depth and the bit positions of every field in the 34-bit
//   instruction word.
package accel_pkg;

  localparam int ROW     = 8;     // activation lanes per word
  localparam int COL     = 8;     // output channels
  localparam int BW      = 4;     // activation / weight width
  localparam int PSUM_BW = 16;    // partial-sum width
  localparam int NUM     = 2048;  // xmem / pmem depth
  localparam int ADDR_W  = 11;    // xmem / pmem address width
  localparam int INST_W  = 34;

  // Instruction word layout.
  localparam int ACC       = 33;
  localparam int CEN_PMEM  = 32;
  localparam int WEN_PMEM  = 31;
  localparam int A_PMEM_HI = 30;
  localparam int A_PMEM_LO = 20;
  localparam int CEN_XMEM  = 19;
  localparam int WEN_XMEM  = 18;
  localparam int A_XMEM_HI = 17;
  localparam int A_XMEM_LO = 7;
  localparam int OFIFO_RD  = 6;
  localparam int IFIFO_WR  = 5;
  localparam int IFIFO_RD  = 4;
  localparam int L0_RD     = 3;
  localparam int L0_WR     = 2;
  localparam int EXECUTE   = 1;
  localparam int LOAD      = 0;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
//   Single-clock FIFO used for the L0 activation buffer, the weight input
//   FIFO and the output FIFO.
//   Ports:
//     clk, reset    clock, asynchronous active-high reset (empties the FIFO)
//     push, din     write request and data; dropped when full unless a pop
//                   happens on the same edge
//     pop           removes the head; ignored when empty
//     dout          current head (stale when empty)
//     empty, full   occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts it.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_ptr_q];

  // NOTE: storage is deliberately left out of the reset; only the pointers
  // and count define what is valid, and a resettable array costs a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/accel_core.sv
// accel_core
//   Compute core of the 2D accelerator: activation SRAM (xmem) -> L0 FIFO ->
//   weight-stationary row x col MAC array -> output FIFO -> partial-sum SRAM
//   (pmem) -> per-column accumulate + ReLU stage.
//   Ports:
//     clk      single clock, all state on the rising edge
//     reset    asynchronous, active-high
//     inst     34-bit instruction word (field positions in accel_pkg)
//     D_xmem   write data for xmem and the weight FIFO; lane r = [bw*r +: bw]
//     valid    output FIFO non-empty
//     coreOut  ReLU of the accumulators; column c = [psum_bw*c +: psum_bw]
module accel_core
  import accel_pkg::*;
#(
  parameter int row     = ROW,
  parameter int col     = COL,
  parameter int bw      = BW,
  parameter int psum_bw = PSUM_BW,
  parameter int num     = NUM
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INST_W-1:0]      inst,
  input  logic [bw*row-1:0]      D_xmem,
  output logic                   valid,
  output logic [col*psum_bw-1:0] coreOut
);

  localparam int AW    = row * bw;
  localparam int OW    = col * psum_bw;
  localparam int PTR_W = (col > 1) ? $clog2(col) : 1;

  // Instruction decode.
  logic              acc, cen_pmem, wen_pmem, cen_xmem, wen_xmem;
  logic              ofifo_rd, ififo_wr, ififo_rd, l0_rd, l0_wr, execute, load;
  logic [ADDR_W-1:0] a_pmem, a_xmem;

  assign acc      = inst[ACC];
  assign cen_pmem = inst[CEN_PMEM];
  assign wen_pmem = inst[WEN_PMEM];
  assign a_pmem   = inst[A_PMEM_HI:A_PMEM_LO];
  assign cen_xmem = inst[CEN_XMEM];
  assign wen_xmem = inst[WEN_XMEM];
  assign a_xmem   = inst[A_XMEM_HI:A_XMEM_LO];
  assign ofifo_rd = inst[OFIFO_RD];
  assign ififo_wr = inst[IFIFO_WR];
  assign ififo_rd = inst[IFIFO_RD];
  assign l0_rd    = inst[L0_RD];
  assign l0_wr    = inst[L0_WR];
  assign execute  = inst[EXECUTE];
  assign load     = inst[LOAD];

  // ---------------------------------------------------------------- xmem
  logic [AW-1:0] xmem_mem [num];
  logic [AW-1:0] xmem_q;

  always_ff @(posedge clk) begin
    if (!cen_xmem && !wen_xmem) xmem_mem[a_xmem] <= D_xmem;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      xmem_q <= '0;
    else if (!cen_xmem && wen_xmem) xmem_q <= xmem_mem[a_xmem];
  end

  // ------------------------------------------------------- input FIFOs
  logic [AW-1:0] l0_dout, ififo_dout;
  logic          l0_empty, ififo_empty;
  logic          l0_full, ififo_full, ofifo_full;

  sync_fifo #(.WIDTH(AW), .DEPTH(64)) u_l0 (
    .clk  (clk),
    .reset(reset),
    .push (l0_wr),
    .pop  (l0_rd),
    .din  (xmem_q),
    .dout (l0_dout),
    .empty(l0_empty),
    .full (l0_full)
  );

  sync_fifo #(.WIDTH(AW), .DEPTH(16)) u_ififo (
    .clk  (clk),
    .reset(reset),
    .push (ififo_wr),
    .pop  (ififo_rd),
    .din  (D_xmem),
    .dout (ififo_dout),
    .empty(ififo_empty),
    .full (ififo_full)
  );

  // Full flags are not needed: a push into a full FIFO is simply dropped.
  logic unused_full;
  assign unused_full = l0_full ^ ififo_full ^ ofifo_full;

  // -------------------------------------------------------- weight load
  logic signed [bw-1:0] w_q [row][col];
  logic [PTR_W-1:0]     w_ptr_q;
  logic                 load_fire;

  assign load_fire = load & ififo_rd & ~ififo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr_q <= '0;
      for (int r = 0; r < row; r++)
        for (int c = 0; c < col; c++) w_q[r][c] <= '0;
    end else if (load_fire) begin
      for (int r = 0; r < row; r++) w_q[r][w_ptr_q] <= ififo_dout[bw*r +: bw];
      w_ptr_q <= (w_ptr_q == PTR_W'(col - 1)) ? '0 : w_ptr_q + PTR_W'(1);
    end
  end

  // ----------------------------------------------------------- MAC array
  // Dot products are formed from the L0 head and the current weights and
  // registered on the pop edge, so a weight load on that same edge does not
  // leak into the result. The registered sums enter the OFIFO one edge later.
  logic          exec_fire;
  logic [OW-1:0] psum_d, psum_q;
  logic          fire_q;

  assign exec_fire = execute & l0_rd & ~l0_empty;

  // NOTE: every always_comb output gets a default before any conditional
  // update, otherwise a path that skips the assignment infers a latch.
  always_comb begin : mac
    logic [psum_bw-1:0] col_sum;
    psum_d = '0;
    for (int c = 0; c < col; c++) begin
      col_sum = '0;
      for (int r = 0; r < row; r++) begin
        // Activation zero-extends (unsigned), weight sign-extends (signed).
        col_sum = col_sum + psum_bw'(l0_dout[bw*r +: bw]) * psum_bw'(w_q[r][c]);
      end
      psum_d[psum_bw*c +: psum_bw] = col_sum;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      psum_q <= '0;
      fire_q <= 1'b0;
    end else begin
      fire_q <= exec_fire;
      if (exec_fire) psum_q <= psum_d;
    end
  end

  // --------------------------------------------------------- output FIFO
  logic [OW-1:0] ofifo_dout;
  logic          ofifo_empty;

  sync_fifo #(.WIDTH(OW), .DEPTH(64)) u_ofifo (
    .clk  (clk),
    .reset(reset),
    .push (fire_q),
    .pop  (ofifo_rd),
    .din  (psum_q),
    .dout (ofifo_dout),
    .empty(ofifo_empty),
    .full (ofifo_full)
  );

  assign valid = ~ofifo_empty;

  // ---------------------------------------------------------------- pmem
  logic [OW-1:0] pmem_mem [num];
  logic [OW-1:0] pmem_q;

  // Writes capture the OFIFO head as it stands before any pop on this edge.
  always_ff @(posedge clk) begin
    if (!cen_pmem && !wen_pmem) pmem_mem[a_pmem] <= ofifo_dout;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      pmem_q <= '0;
    else if (!cen_pmem && wen_pmem) pmem_q <= pmem_mem[a_pmem];
  end

  // ----------------------------------------------------------------- SFP
  // The first acc cycle of a run loads pmem_q; following consecutive acc
  // cycles add to it.
  logic [psum_bw-1:0] acc_q [col];
  logic               acc_prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_prev_q <= 1'b0;
      for (int c = 0; c < col; c++) acc_q[c] <= '0;
    end else begin
      acc_prev_q <= acc;
      if (acc) begin
        for (int c = 0; c < col; c++)
          acc_q[c] <= acc_prev_q ? acc_q[c] + pmem_q[psum_bw*c +: psum_bw]
                                 : pmem_q[psum_bw*c +: psum_bw];
      end
    end
  end

  always_comb begin
    coreOut = '0;
    for (int c = 0; c < col; c++)
      coreOut[psum_bw*c +: psum_bw] = acc_q[c][psum_bw-1] ? '0 : acc_q[c];
  end

endmodule

// File: tb/tb_accel_core.sv
`timescale 1ns/1ps
module tb_accel_core;
  import accel_pkg::*;

  localparam int W  = ROW * BW;
  localparam int OW = COL * PSUM_BW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [INST_W-1:0] inst;
  logic [W-1:0]      D_xmem;
  logic              valid;
  logic [OW-1:0]     coreOut;

  accel_core dut (
    .clk    (clk),
    .reset  (reset),
    .inst   (inst),
    .D_xmem (D_xmem),
    .valid  (valid),
    .coreOut(coreOut)
  );

  always #5 clk = ~clk;

  // ------------------------------------------------ reference model state
  logic [W-1:0]       m_xmem [int];
  logic [OW-1:0]      m_pmem [int];
  logic [W-1:0]       m_xq;
  logic [OW-1:0]      m_pq;
  logic [W-1:0]       m_l0 [$];
  logic [W-1:0]       m_if [$];
  logic [OW-1:0]      m_of [$];
  int                 m_w [ROW][COL];
  int                 m_ptr;
  logic [PSUM_BW-1:0] m_acc [COL];
  logic               m_prev;
  logic               m_pend_v;
  logic [OW-1:0]      m_pend;

  typedef struct packed {
    logic [15:0]   tag;
    logic          v;
    logic [OW-1:0] d;
  } exp_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   phase = 0;

  logic [INST_W-1:0] I_NOP, I_IW, I_LD, I_L0W, I_L0R, I_EX, I_ORD, I_ACC;

  // ------------------------------------------------------------- helpers
  function automatic logic [INST_W-1:0] nop();
    logic [INST_W-1:0] r;
    r = '0;
    r[CEN_PMEM] = 1'b1;
    r[CEN_XMEM] = 1'b1;
    return r;
  endfunction

  function automatic logic [INST_W-1:0] xw(logic [INST_W-1:0] b, int a);
    b[CEN_XMEM] = 1'b0; b[WEN_XMEM] = 1'b0; b[A_XMEM_HI:A_XMEM_LO] = ADDR_W'(a);
    return b;
  endfunction

  function automatic logic [INST_W-1:0] xr(logic [INST_W-1:0] b, int a);
    b[CEN_XMEM] = 1'b0; b[WEN_XMEM] = 1'b1; b[A_XMEM_HI:A_XMEM_LO] = ADDR_W'(a);
    return b;
  endfunction

  function automatic logic [INST_W-1:0] pw(logic [INST_W-1:0] b, int a);
    b[CEN_PMEM] = 1'b0; b[WEN_PMEM] = 1'b0; b[A_PMEM_HI:A_PMEM_LO] = ADDR_W'(a);
    return b;
  endfunction

  function automatic logic [INST_W-1:0] pr(logic [INST_W-1:0] b, int a);
    b[CEN_PMEM] = 1'b0; b[WEN_PMEM] = 1'b1; b[A_PMEM_HI:A_PMEM_LO] = ADDR_W'(a);
    return b;
  endfunction

  // Column c = sum over rows of unsigned activation times signed weight, mod 2^16.
  function automatic logic [OW-1:0] dot(logic [W-1:0] act);
    logic [OW-1:0] res;
    int s;
    res = '0;
    for (int c = 0; c < COL; c++) begin
      s = 0;
      for (int r = 0; r < ROW; r++) s += int'(act[BW*r +: BW]) * m_w[r][c];
      res[PSUM_BW*c +: PSUM_BW] = s[PSUM_BW-1:0];
    end
    return res;
  endfunction

  task automatic model_reset();
    m_xq = '0; m_pq = '0;
    m_l0.delete(); m_if.delete(); m_of.delete();
    for (int r = 0; r < ROW; r++)
      for (int c = 0; c < COL; c++) m_w[r][c] = 0;
    m_ptr = 0;
    for (int c = 0; c < COL; c++) m_acc[c] = '0;
    m_prev = 1'b0; m_pend_v = 1'b0; m_pend = '0;
  endtask

  // One clock edge of the core, all effects computed from pre-edge state.
  task automatic model_step(input logic [INST_W-1:0] in, input logic [W-1:0] d);
    logic [W-1:0]  old_xq, l0_head, if_head;
    logic [OW-1:0] old_pq, of_head, new_pend;
    logic          l0_pop, if_pop, of_pop, new_pend_v;
    int            xa, pa;
    old_xq  = m_xq;
    old_pq  = m_pq;
    xa      = int'(in[A_XMEM_HI:A_XMEM_LO]);
    pa      = int'(in[A_PMEM_HI:A_PMEM_LO]);
    l0_pop  = in[L0_RD] && m_l0.size() > 0;
    if_pop  = in[IFIFO_RD] && m_if.size() > 0;
    of_pop  = in[OFIFO_RD] && m_of.size() > 0;
    l0_head = (m_l0.size() > 0) ? m_l0[0] : '0;
    if_head = (m_if.size() > 0) ? m_if[0] : '0;
    of_head = (m_of.size() > 0) ? m_of[0] : '0;
    new_pend_v = in[EXECUTE] && l0_pop;
    new_pend   = dot(l0_head);

    if (in[ACC])
      for (int c = 0; c < COL; c++)
        m_acc[c] = m_prev ? m_acc[c] + old_pq[PSUM_BW*c +: PSUM_BW]
                          : old_pq[PSUM_BW*c +: PSUM_BW];
    m_prev = in[ACC];

    if (!in[CEN_PMEM]) begin
      if (!in[WEN_PMEM]) m_pmem[pa] = of_head;
      else               m_pq = m_pmem.exists(pa) ? m_pmem[pa] : '0;
    end
    if (!in[CEN_XMEM]) begin
      if (!in[WEN_XMEM]) m_xmem[xa] = d;
      else               m_xq = m_xmem.exists(xa) ? m_xmem[xa] : '0;
    end

    if (l0_pop) void'(m_l0.pop_front());
    if (in[L0_WR] && m_l0.size() < 64) m_l0.push_back(old_xq);

    if (if_pop) void'(m_if.pop_front());
    if (in[IFIFO_WR] && m_if.size() < 16) m_if.push_back(d);
    if (in[LOAD] && if_pop) begin
      for (int r = 0; r < ROW; r++) m_w[r][m_ptr] = int'($signed(if_head[BW*r +: BW]));
      m_ptr = (m_ptr + 1) % COL;
    end

    if (of_pop) void'(m_of.pop_front());
    if (m_pend_v && m_of.size() < 64) m_of.push_back(m_pend);
    m_pend_v = new_pend_v;
    m_pend   = new_pend;
  endtask

  task automatic push_expect();
    exp_t e;
    e.tag = 16'(phase);
    e.v   = (m_of.size() > 0);
    e.d   = '0;
    for (int c = 0; c < COL; c++)
      e.d[PSUM_BW*c +: PSUM_BW] = m_acc[c][PSUM_BW-1] ? '0 : m_acc[c];
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic [INST_W-1:0] in, input logic [W-1:0] d);
    @(negedge clk);
    inst = in; D_xmem = d;
    @(posedge clk);
    model_step(in, d);
    #1 push_expect();
  endtask

  task automatic check(input logic [15:0] tag, input logic act_v, input logic [OW-1:0] act_d,
                       input logic exp_v, input logic [OW-1:0] exp_d);
    n_checks++;
    if (act_v !== exp_v || act_d !== exp_d) begin
      n_errors++;
      $display("FAIL phase%0d t=%0t: valid=%0b coreOut=%h, expected valid=%0b coreOut=%h",
               tag, $time, act_v, act_d, exp_v, exp_d);
    end
  endtask

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check(mon_e.tag, valid, coreOut, mon_e.v, mon_e.d);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------ stimulus
  initial begin
    I_NOP = nop();
    I_IW  = I_NOP; I_IW[IFIFO_WR] = 1'b1;
    I_LD  = I_NOP; I_LD[LOAD] = 1'b1; I_LD[IFIFO_RD] = 1'b1;
    I_L0W = I_NOP; I_L0W[L0_WR] = 1'b1;
    I_L0R = I_NOP; I_L0R[L0_RD] = 1'b1;
    I_EX  = I_NOP; I_EX[EXECUTE] = 1'b1; I_EX[L0_RD] = 1'b1;
    I_ORD = I_NOP; I_ORD[OFIFO_RD] = 1'b1;
    I_ACC = I_NOP; I_ACC[ACC] = 1'b1;
    inst = I_NOP; D_xmem = '0;
    model_reset();

    // Reset held: outputs stay zero.
    repeat (10) begin @(negedge clk); #1 push_expect(); end
    @(negedge clk); reset = 1'b0;
    repeat (2) cycle(I_NOP, '0);

    // Basic flow: activations 2, weights 1 -> 16 per column.
    phase = 1;
    cycle(xw(I_NOP, 0), 32'h2222_2222);
    repeat (8) cycle(I_IW, 32'h1111_1111);
    repeat (8) cycle(I_LD, '0);
    cycle(xr(I_NOP, 0), '0);
    cycle(I_L0W, '0);
    cycle(I_EX, '0);
    cycle(I_NOP, '0);
    cycle(pw(I_ORD, 5), '0);
    cycle(pr(I_NOP, 5), '0);
    cycle(I_ACC, '0);
    cycle(I_ACC, '0);
    cycle(I_NOP, '0);
    cycle(I_ACC, '0);
    cycle(I_NOP, '0);

    // Negative column sum (-120) is clipped by ReLU.
    phase = 2;
    repeat (8) cycle(I_IW, 32'hFFFF_FFFF);
    repeat (8) cycle(I_LD, '0);
    cycle(xw(I_NOP, 1), 32'hFFFF_FFFF);
    cycle(xr(I_NOP, 1), '0);
    cycle(I_L0W, '0);
    cycle(I_EX, '0);
    cycle(I_NOP, '0);
    cycle(pw(I_ORD, 6), '0);
    cycle(pr(I_NOP, 6), '0);
    cycle(I_ACC, '0);
    cycle(I_NOP, '0);

    // Accumulator wrap: 151 x 217 = 0x7FFF, then +1 -> 0x8000.
    phase = 3;
    repeat (8) cycle(I_IW, 32'h0000_0771);
    repeat (8) cycle(I_LD, '0);
    cycle(xw(I_NOP, 2), 32'h0000_0FF7);
    cycle(xw(I_NOP, 3), 32'h0000_0001);
    cycle(xr(I_NOP, 2), '0);
    cycle(xr(I_L0W, 3), '0);
    cycle(I_L0W, '0);
    cycle(I_EX, '0);
    cycle(I_EX, '0);
    cycle(I_NOP, '0);
    cycle(pw(I_ORD, 7), '0);
    cycle(pw(I_ORD, 8), '0);
    cycle(pr(I_NOP, 7), '0);
    for (int k = 1; k <= 151; k++) cycle((k == 151) ? pr(I_ACC, 8) : I_ACC, '0);
    cycle(I_ACC, '0);
    cycle(I_NOP, '0);

    // L0 overflow: 65 pushes keep 64; the 65th execute finds L0 empty.
    phase = 4;
    cycle(xw(I_NOP, 4), 32'h0000_0001);
    cycle(xr(I_NOP, 4), '0);
    repeat (65) cycle(I_L0W, '0);
    repeat (63) cycle(I_L0R, '0);
    cycle(I_EX, '0);
    cycle(I_NOP, '0);
    cycle(I_EX, '0);
    cycle(I_NOP, '0);
    cycle(I_ORD, '0);
    cycle(I_NOP, '0);
    cycle(I_NOP, '0);

    // Ninth load wraps w_ptr and overwrites column 0.
    phase = 5;
    for (int k = 0; k < 8; k++) cycle(I_IW, {8{4'(k)}});
    cycle(I_IW, 32'h5555_5555);
    repeat (9) cycle(I_LD, '0);
    cycle(xw(I_NOP, 5), 32'h1111_1111);
    cycle(xr(I_NOP, 5), '0);
    cycle(I_L0W, '0);
    cycle(I_EX, '0);
    cycle(I_NOP, '0);
    cycle(pw(I_ORD, 9), '0);
    cycle(pr(I_NOP, 9), '0);
    cycle(I_ACC, '0);
    cycle(I_NOP, '0);

    // Load and execute on the same edge: execute sees the old weights.
    phase = 6;
    cycle(I_IW, 32'h7777_7777);
    cycle(xr(I_NOP, 5), '0);
    cycle(I_L0W, '0);
    cycle(I_LD | I_EX, '0);
    cycle(I_NOP, '0);
    cycle(pw(I_ORD, 10), '0);
    cycle(pr(I_NOP, 10), '0);
    cycle(I_ACC, '0);
    cycle(I_NOP, '0);

    // Randomized weights, activations and addresses.
    for (int it = 0; it < 12; it++) begin
      int xa, pa;
      phase = 100 + it;
      xa = int'($urandom_range(0, NUM - 1));
      pa = int'($urandom_range(0, NUM - 1));
      repeat (8) cycle(I_IW, $urandom());
      repeat (8) cycle(I_LD, '0);
      cycle(xw(I_NOP, xa), $urandom());
      cycle(xr(I_NOP, xa), '0);
      cycle(I_L0W, '0);
      cycle(I_EX, '0);
      cycle(I_NOP, '0);
      cycle(pw(I_ORD, pa), '0);
      if ($urandom_range(0, 1) == 1) cycle(I_EX | I_ORD, '0);
      cycle(pr(I_NOP, pa), '0);
      repeat (1 + $urandom_range(0, 2)) cycle(I_ACC, '0);
      cycle(I_NOP, '0);
    end

    // Reset asserted with an OFIFO entry present and an execute in flight.
    phase = 7;
    repeat (8) cycle(I_IW, 32'h1111_1111);
    repeat (8) cycle(I_LD, '0);
    cycle(xr(I_NOP, 0), '0);
    cycle(I_L0W, '0);
    cycle(I_L0W, '0);
    cycle(I_EX, '0);
    cycle(I_NOP, '0);
    cycle(pw(I_NOP, 11), '0);
    cycle(pr(I_NOP, 11), '0);
    cycle(I_ACC, '0);
    cycle(I_NOP, '0);
    @(negedge clk);
    inst = I_EX;
    @(posedge clk);
    model_step(I_EX, '0);
    #2;
    reset = 1'b1;
    model_reset();
    push_expect();
    inst = I_NOP;
    @(negedge clk);
    #1 push_expect();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) cycle(I_NOP, '0);

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
